// File: rtl/axis_upsizer_n.sv
// axis_upsizer_n: packs N W-bit AXI-Stream beats into one N*W-bit word; ports aclk/aresetn, in_t{data,last,valid,ready}, out_t{data,keep,last,valid,ready}
module axis_upsizer_n #(
  parameter int W         = 40,
  parameter int N         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [W-1:0]   in_tdata,
  input  logic           in_tlast,
  input  logic           in_tvalid,
  output logic           in_tready,
  output logic [N*W-1:0] out_tdata,
  output logic [N-1:0]   out_tkeep,
  output logic           out_tlast,
  output logic           out_tvalid,
  input  logic           out_tready
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [N*W-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d, word_data;
  logic [N-1:0]   acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, word_keep, kx;
  logic [CW-1:0]  cnt_q, cnt_d, lane;
  logic           acc_last_q, acc_last_d, out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic           pend_q, pend_d;
  logic           slot_free, acc_in, load_pend, load_new, done, contig;
  always_comb begin
    slot_free   = !out_valid_q | out_tready;
    in_tready   = !pend_q | slot_free;
    acc_in      = in_tvalid & in_tready;
    load_pend   = pend_q & slot_free;
    lane        = (MSB_FIRST != 0) ? LAST - cnt_q : cnt_q;
    done        = acc_in & ((cnt_q == LAST) | in_tlast);
    load_new    = done & slot_free & !pend_q;
    // a departing pending word leaves an empty accumulator for this cycle's beat
    for (int k = 0; k < N; k++) begin
      word_data[k*W +: W] = (acc_in && lane == CW'(k)) ? in_tdata
                          : load_pend ? '0 : acc_data_q[k*W +: W];
      word_keep[k]        = (acc_in && lane == CW'(k)) | (!load_pend & acc_keep_q[k]);
    end
    acc_data_d  = load_new ? '0 : word_data;
    acc_keep_d  = load_new ? '0 : word_keep;
    acc_last_d  = done ? in_tlast : acc_last_q;
    cnt_d       = done ? '0 : acc_in ? cnt_q + CW'(1) : cnt_q;
    pend_d      = (pend_q & !slot_free) | (done & !load_new);
    out_data_d  = load_pend ? acc_data_q : load_new ? word_data : out_data_q;
    out_keep_d  = load_pend ? acc_keep_q : load_new ? word_keep : out_keep_q;
    out_last_d  = load_pend ? acc_last_q : load_new ? in_tlast : out_last_q;
    out_valid_d = load_pend | load_new | (out_valid_q & !out_tready);
    kx          = (MSB_FIRST != 0) ? ~out_keep_q : out_keep_q;
    contig      = ((kx + N'(1)) & kx) == '0;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      acc_last_q  <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      acc_last_q  <= acc_last_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_tdata  = out_data_q;
  assign out_tkeep  = out_keep_q;
  assign out_tlast  = out_last_q;
  assign out_tvalid = out_valid_q;
  a_hold:   assert property (@(posedge aclk) disable iff (!aresetn) out_tvalid && !out_tready |=> out_tvalid);
  a_stable: assert property (@(posedge aclk) disable iff (!aresetn)
                             out_tvalid && !out_tready |=> $stable(out_tdata) && $stable(out_tkeep));
  a_pend:   assert property (@(posedge aclk) disable iff (!aresetn) pend_q |-> out_tvalid);
  a_keep:   assert property (@(posedge aclk) disable iff (!aresetn) out_tvalid |-> out_tkeep != '0);
  a_contig: assert property (@(posedge aclk) disable iff (!aresetn) out_tvalid |-> contig);
endmodule

// File: tb/tb_axis_upsizer_n.sv
// tb_axis_upsizer_n: directed vector bench for both lane orders of axis_upsizer_n (W=8, N=4)
module tb_axis_upsizer_n;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  in_tdata;
  logic        in_tlast, in_tvalid, out_tready;
  logic        rdy0, rdy1, ov0, ov1, ol0, ol1;
  logic [31:0] od0, od1;
  logic [3:0]  ok0, ok1;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct {
    logic [7:0]  d;
    logic        last, vld, rdy, e_rdy, e_ov;
    logic [31:0] e_d0;
    logic [3:0]  e_k0;
    logic [31:0] e_d1;
    logic [3:0]  e_k1;
    logic        e_last;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  axis_upsizer_n #(.W(8), .N(4), .MSB_FIRST(0)) u0 (
    .aclk(clk), .aresetn(aresetn), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(rdy0), .out_tdata(od0), .out_tkeep(ok0),
    .out_tlast(ol0), .out_tvalid(ov0), .out_tready(out_tready));
  axis_upsizer_n #(.W(8), .N(4), .MSB_FIRST(1)) u1 (
    .aclk(clk), .aresetn(aresetn), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(rdy1), .out_tdata(od1), .out_tkeep(ok1),
    .out_tlast(ol1), .out_tvalid(ov1), .out_tready(out_tready));
  function automatic vec_t v(logic [7:0] d, logic last, logic vld, logic rdy, logic e_rdy, logic e_ov,
                             logic [31:0] e_d0 = 0, logic [3:0] e_k0 = 0, logic [31:0] e_d1 = 0,
                             logic [3:0] e_k1 = 0, logic e_last = 0);
    vec_t r;
    r.d = d; r.last = last; r.vld = vld; r.rdy = rdy; r.e_rdy = e_rdy; r.e_ov = e_ov;
    r.e_d0 = e_d0; r.e_k0 = e_k0; r.e_d1 = e_d1; r.e_k1 = e_k1; r.e_last = e_last;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(logic [7:0] d, logic last, logic vld, logic rdy);
    @(negedge clk);
    in_tdata = d; in_tlast = last; in_tvalid = vld; out_tready = rdy;
    #1;
  endtask
  task automatic chk_idle(string nm);
    chk({nm, " rdy0"}, 32'(rdy0), 32'h1);
    chk({nm, " rdy1"}, 32'(rdy1), 32'h1);
    chk({nm, " ov0"}, 32'(ov0), 32'h0);
    chk({nm, " ov1"}, 32'(ov1), 32'h0);
    chk({nm, " od0"}, od0, 32'h0);
    chk({nm, " od1"}, od1, 32'h0);
    chk({nm, " ok0"}, 32'(ok0), 32'h0);
    chk({nm, " ok1"}, 32'(ok1), 32'h0);
    chk({nm, " ol0"}, 32'(ol0), 32'h0);
    chk({nm, " ol1"}, 32'(ol1), 32'h0);
  endtask
  initial begin
    tv.push_back(v(8'h11, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h22, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h33, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h44, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h44332211, 4'hF, 32'h11223344, 4'hF, 0));
    tv.push_back(v(8'hA1, 0, 1, 1, 1, 0));
    tv.push_back(v(8'hA2, 1, 1, 1, 1, 0));
    tv.push_back(v(8'h55, 0, 1, 1, 1, 1, 32'h0000A2A1, 4'h3, 32'hA1A20000, 4'hC, 1));
    tv.push_back(v(8'h66, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h77, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h88, 0, 1, 1, 1, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h88776655, 4'hF, 32'h55667788, 4'hF, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 0));
    for (int i = 1; i <= 4; i++) tv.push_back(v(8'(i), 0, 1, 0, 1, 0));
    for (int i = 5; i <= 8; i++)
      tv.push_back(v(8'(i), 0, 1, 0, 1, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0));
    tv.push_back(v(8'h09, 0, 1, 0, 0, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0));
    tv.push_back(v(8'h09, 0, 1, 1, 1, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h08070605, 4'hF, 32'h05060708, 4'hF, 0));
    tv.push_back(v(8'h0A, 1, 1, 1, 1, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h00000A09, 4'h3, 32'h090A0000, 4'hC, 1));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) tv.push_back(v(8'h11 + 8'(i), 0, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(v(8'h21 + 8'(i), 0, 1, 0, 1, 1, 32'h14131211, 4'hF, 32'h11121314, 4'hF, 0));
    tv.push_back(v(8'hEE, 1, 1, 1, 1, 1, 32'h14131211, 4'hF, 32'h11121314, 4'hF, 0));
    tv.push_back(v(8'h00, 0, 0, 0, 0, 1, 32'h24232221, 4'hF, 32'h21222324, 4'hF, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h24232221, 4'hF, 32'h21222324, 4'hF, 0));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 1, 32'h000000EE, 4'h1, 32'hEE000000, 4'h8, 1));
    tv.push_back(v(8'h00, 0, 0, 1, 1, 0));
    aresetn = 1'b0; in_tdata = 8'hFF; in_tlast = 1'b1; in_tvalid = 1'b1; out_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    aresetn = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].last, tv[i].vld, tv[i].rdy);
      chk($sformatf("v%0d rdy0", i), 32'(rdy0), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d rdy1", i), 32'(rdy1), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d ov0", i), 32'(ov0), 32'(tv[i].e_ov));
      chk($sformatf("v%0d ov1", i), 32'(ov1), 32'(tv[i].e_ov));
      if (tv[i].e_ov) begin
        chk($sformatf("v%0d od0", i), od0, tv[i].e_d0);
        chk($sformatf("v%0d ok0", i), 32'(ok0), 32'(tv[i].e_k0));
        chk($sformatf("v%0d ol0", i), 32'(ol0), 32'(tv[i].e_last));
        chk($sformatf("v%0d od1", i), od1, tv[i].e_d1);
        chk($sformatf("v%0d ok1", i), 32'(ok1), 32'(tv[i].e_k1));
        chk($sformatf("v%0d ol1", i), 32'(ol1), 32'(tv[i].e_last));
      end
    end
    for (int i = 0; i < 4; i++) drive(8'h41 + 8'(i), 0, 1, 0);
    drive(8'h31, 0, 1, 0);
    drive(8'h32, 0, 1, 0);
    drive(8'h00, 0, 0, 0);
    chk("pre-rst ov0", 32'(ov0), 32'h1);
    chk("pre-rst od0", od0, 32'h44434241);
    #2 aresetn = 1'b0;
    #1 chk_idle("async rst");
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'h51 + 8'(i), 0, 1, 1);
    drive(8'h00, 0, 0, 1);
    chk("post-rst ov0", 32'(ov0), 32'h1);
    chk("post-rst od0", od0, 32'h54535251);
    chk("post-rst ok0", 32'(ok0), 32'hF);
    chk("post-rst ol0", 32'(ol0), 32'h0);
    chk("post-rst od1", od1, 32'h51525354);
    drive(8'h00, 0, 0, 1);
    chk("post-rst drain", 32'(ov0), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axis_upsizer_n.md
# axis_upsizer_n

Parametrised AXI-Stream width upsizer: packs N consecutive W-bit input beats into one N*W-bit output beat, with a selectable lane order. Input `tlast` flushes a partial word, marked by per-lane `out_tkeep`. Full throughput: one output word per N accepted input beats, no bubbles while the downstream is ready. It sits on stream paths between a narrow producer and a wide consumer, and generalises the fixed 2:1 upsizer.

## Interface
- `W`, 40: input lane width in bits, ≥1.
- `N`, 4: packing ratio, ≥2.
- `MSB_FIRST`, 0: 0 places the first beat in lane 0 (LSBs); 1 places it in lane N-1 (MSBs).
- Lane k occupies bits [k*W +: W] of `out_tdata`.
- Clock and reset: one clock, `aclk`; reset `aresetn` is asynchronous and active-low.
- `aclk` in 1: clock, rising edge.
- `aresetn` in 1: asynchronous active-low reset.
- `in_tdata` in W: input beat data.
- `in_tlast` in 1: last beat of a packet; closes the current word.
- `in_tvalid` in 1: input valid.
- `in_tready` out 1: input ready.
- `out_tdata` out N*W: packed word.
- `out_tkeep` out N: per-lane valid; bit k qualifies lane k.
- `out_tlast` out 1: word closed by `in_tlast`.
- `out_tvalid` out 1: output valid.
- `out_tready` in 1: output ready.

## Operation
- Internal state:
  - accumulator of N*W data plus N keep bits;
  - beat counter `cnt`, 0..N-1;
  - `pend` flag, set when the accumulator holds a complete word;
  - output register for `out_tdata`, `out_tkeep`, `out_tlast` and `out_tvalid`.
- Definitions:
  - `acc_in = in_tvalid & in_tready`.
  - `slot_free = !out_tvalid | out_tready`.
  - `in_tready = !pend | slot_free`. This is the only combinational in-to-out path.
- An accepted beat writes lane L, where L = `cnt` if `MSB_FIRST` = 0 and L = N-1-`cnt` if `MSB_FIRST` = 1, and sets keep bit L.
- An accepted beat completes the word when `cnt` == N-1 or `in_tlast` = 1.
  - Word data: accumulator contents plus the current beat.
  - Lanes not written hold zero data and keep = 0.
  - `out_tlast` = `in_tlast` of the completing beat.
- Handling of a completed word:
  - `slot_free` and `pend` = 0: the word loads the output register directly, `out_tvalid` is set, and the accumulator clears.
  - `slot_free` = 0: the word stays in the accumulator and `pend` is set.
- When `pend` = 1 and `slot_free` = 1, the pending word moves to the output register and `pend` clears.
  - An input beat accepted in the same cycle starts a fresh accumulator at `cnt` = 0.
  - If that beat carries `in_tlast`, it sets `pend` again with a one-lane word.
- `cnt` increments on each non-completing accepted beat and returns to 0 on completion.
- If `out_tvalid` = 1, `out_tready` = 1 and no new word loads, `out_tvalid` clears.
- The output register does not change while `out_tvalid` = 1 and `out_tready` = 0.
- Reset (asynchronous, any time):
  - `cnt` = 0, `pend` = 0;
  - accumulator cleared, so any partial word is discarded;
  - `out_tvalid` = 0, `out_tdata` = 0, `out_tkeep` = 0, `out_tlast` = 0.
- Reset values of the remaining output and internal signals:
  - `in_tready` = 1 during reset and after release (`pend` = 0).
  - No transfer is accepted while `aresetn` = 0.
- Assertions (disabled in reset):
  - `out_tvalid` is never dropped without `out_tready`.
  - `out_tdata` and `out_tkeep` are stable while stalled.
  - `pend` implies `out_tvalid`.
  - `out_tkeep` is never 0 when `out_tvalid` = 1.
  - `out_tkeep` is contiguous from the first lane.

## Timing
- Latency: `out_tvalid` rises on the edge that accepts the completing beat, so data is visible the next cycle.
- With `out_tready` held at 1, a full word appears every N input cycles and `in_tready` stays 1.
- Backpressure: while a word waits at the output, the accumulator keeps filling. It stalls only when a second word has completed (`pend` = 1), and resumes in the cycle `out_tready` = 1.
- A `tlast` at `cnt` = 0 yields a one-lane word with `out_tkeep` = one-hot of the first lane.
- Simultaneous events in one cycle: output drain, pending-word transfer and new beat acceptance are all legal together.

## Test plan
- Continuous fill (N = 4, W = 8, `MSB_FIRST` = 0, `out_tready` = 1, beats 0x11, 0x22, 0x33, 0x44) -> one word: `out_tdata` = 0x44332211, `out_tkeep` = 0xF, `out_tlast` = 0. `out_tvalid` is high exactly one cycle after the 4th acceptance, and `in_tready` never drops.
- `MSB_FIRST` = 1, same beats -> `out_tdata` = 0x11223344.
- Partial flush: beats 0xA1, 0xA2 with `tlast` on 0xA2 -> `out_tdata` = 0x0000A2A1, `out_tkeep` = 0x3, `out_tlast` = 1. The next beat lands in lane 0.
- Backpressure: hold `out_tready` = 0 and stream 8 beats -> word 1 is held stable, and word 2 completes into the accumulator with `pend` = 1. `in_tready` = 0 from the cycle after the 8th acceptance. Raising `out_tready` drains both words in order, and `in_tready` returns to 1 the same cycle.
- `tlast` at `cnt` = 0 while `pend` is draining -> single-lane word, `out_tkeep` = 0x1, `out_tlast` = 1, delivered after the pending word.
- Reset mid-word after 2 beats -> all outputs 0 immediately (asynchronous). After release, 4 new beats produce a word with no residue from the discarded beats.
